dmi_arbiter: RTL and testbench

Shares one Debug Module Interface (DMI) master port among NUM_REQ requesters, e.g. the simulation DTM and a JTAG DTM. Requests are granted round-robin, with exactly one transaction outstanding downstream at a time. Each response is routed back to the requester that issued the request. A response timeout returns a failed status so a requester cannot hang.

---
 rtl/dmi_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmi_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI master port among NUM_REQ requesters.
// One transaction is outstanding downstream at a time; a response timeout returns status 2.
//
// state   | meaning
// IDLE    | arbitrate; grant the first valid requester after last_grant
// REQ     | present the latched request downstream until accepted
// RESP    | wait for the downstream response, timer running
// DELIVER | hold the response to the owner until it accepts
module dmi_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 7,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        in_req_valid,
   output logic [NUM_REQ-1:0]        in_req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] in_req_addr,
   input  logic [NUM_REQ*2-1:0]      in_req_op,
   input  logic [NUM_REQ*32-1:0]     in_req_data,
   output logic [NUM_REQ-1:0]        in_resp_valid,
   input  logic [NUM_REQ-1:0]        in_resp_ready,
   output logic [1:0]                in_resp_resp,
   output logic [31:0]               in_resp_data,
   output logic                      dmi_req_valid,
   input  logic                      dmi_req_ready,
   output logic [ADDR_W-1:0]         dmi_req_addr,
   output logic [1:0]                dmi_req_op,
   output logic [31:0]               dmi_req_data,
   input  logic                      dmi_resp_valid,
   output logic                      dmi_resp_ready,
   input  logic [1:0]                dmi_resp_resp,
   input  logic [31:0]               dmi_resp_data,
   output logic                      busy,
   output logic [2:0]                owner,
   output logic                      stray_resp,
   output logic [7:0]                timeout_cnt
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DELIVER} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     owner_q, last_grant, win_idx, cand;
   logic              win_found, accept, timer_tc;
   logic [TW-1:0]     timer;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        op_q, resp_q;
   logic [31:0]       data_q, rdata_q;
   logic [ADDR_W-1:0] req_addr_a [NUM_REQ];
   logic [1:0]        req_op_a   [NUM_REQ];
   logic [31:0]       req_data_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign req_addr_a[g]    = in_req_addr[g*ADDR_W +: ADDR_W];
      assign req_op_a[g]      = in_req_op[g*2 +: 2];
      assign req_data_a[g]    = in_req_data[g*32 +: 32];
      assign in_req_ready[g]  = accept && (win_idx == IW'(g));
      assign in_resp_valid[g] = (state == DELIVER) && (owner_q == IW'(g));
   end

   // Search starts one past the last grant and wraps, giving round-robin fairness.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IW'((int'(last_grant) + i) % NUM_REQ);
         if (!win_found && in_req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign accept   = (state == IDLE) && win_found;
   assign timer_tc = (timer == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = REQ;
         REQ:     if (dmi_req_ready) state_nxt = RESP;
         RESP:    if (dmi_resp_valid || timer_tc) state_nxt = DELIVER;
         DELIVER: if (in_resp_ready[owner_q]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q      <= '0;
         op_q        <= '0;
         data_q      <= '0;
         resp_q      <= '0;
         rdata_q     <= '0;
         owner_q     <= IW'(NUM_REQ - 1);
         last_grant  <= IW'(NUM_REQ - 1);
         timer       <= '0;
         stray_resp  <= 1'b0;
         timeout_cnt <= '0;
      end else begin
         if (accept) begin
            addr_q     <= req_addr_a[win_idx];
            op_q       <= req_op_a[win_idx];
            data_q     <= req_data_a[win_idx];
            owner_q    <= win_idx;
            last_grant <= win_idx;
         end
         // Down-counter: loaded on downstream accept, terminal count marks TIMEOUT cycles in RESP.
         if (state == REQ && dmi_req_ready)
            timer <= TW'(TIMEOUT - 1);
         else if (state == RESP && !timer_tc)
            timer <= timer - 1'b1;
         if (state == RESP) begin
            if (dmi_resp_valid) begin
               resp_q  <= dmi_resp_resp;
               rdata_q <= dmi_resp_data;
            end else if (timer_tc) begin
               resp_q  <= 2'd2;
               rdata_q <= '0;
               if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end
         end
         if (dmi_resp_valid && (state == IDLE || state == DELIVER))
            stray_resp <= 1'b1;
      end
   end

   assign dmi_req_valid  = (state == REQ);
   assign dmi_req_addr   = addr_q;
   assign dmi_req_op     = op_q;
   assign dmi_req_data   = data_q;
   assign dmi_resp_ready = (state != REQ);
   assign in_resp_resp   = resp_q;
   assign in_resp_data   = rdata_q;
   assign busy           = (state != IDLE);
   assign owner          = 3'(owner_q);

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter (NUM_REQ=2, TIMEOUT=16): directed scenarios
// followed by randomized transactions checked against a transaction-level model.
module tb_dmi_arbiter;

   localparam int N  = 2;
   localparam int AW = 7;
   localparam int TO = 16;

   logic          clk, reset;
   logic [N-1:0]  in_req_valid, in_req_ready;
   logic [N*AW-1:0] in_req_addr;
   logic [N*2-1:0]  in_req_op;
   logic [N*32-1:0] in_req_data;
   logic [N-1:0]  in_resp_valid, in_resp_ready;
   logic [1:0]    in_resp_resp;
   logic [31:0]   in_resp_data;
   logic          dmi_req_valid, dmi_req_ready;
   logic [AW-1:0] dmi_req_addr;
   logic [1:0]    dmi_req_op;
   logic [31:0]   dmi_req_data;
   logic          dmi_resp_valid, dmi_resp_ready;
   logic [1:0]    dmi_resp_resp;
   logic [31:0]   dmi_resp_data;
   logic          busy;
   logic [2:0]    owner;
   logic          stray_resp;
   logic [7:0]    timeout_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          lg_m;
   int          tcnt_m;
   logic        stray_m;
   logic [AW-1:0] m_addr [N];
   logic [1:0]    m_op   [N];
   logic [31:0]   m_data [N];

   dmi_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
      .in_req_addr(in_req_addr), .in_req_op(in_req_op), .in_req_data(in_req_data),
      .in_resp_valid(in_resp_valid), .in_resp_ready(in_resp_ready),
      .in_resp_resp(in_resp_resp), .in_resp_data(in_resp_data),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
      .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
      .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data),
      .busy(busy), .owner(owner), .stray_resp(stray_resp), .timeout_cnt(timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_payload();
      in_req_addr = {m_addr[1], m_addr[0]};
      in_req_op   = {m_op[1], m_op[0]};
      in_req_data = {m_data[1], m_data[0]};
   endtask

   task automatic new_payload();
      for (int i = 0; i < N; i++) begin
         m_addr[i] = AW'($urandom);
         m_op[i]   = 2'($urandom);
         m_data[i] = $urandom;
      end
      drive_payload();
   endtask

   function automatic int exp_winner(input logic [N-1:0] mask);
      int r;
      int idx;
      r = -1;
      for (int k = 1; k <= N; k++) begin
         idx = (lg_m + k) % N;
         if (r < 0 && mask[idx]) r = idx;
      end
      return r;
   endfunction

   // One full transaction; returns the requester actually granted by the DUT.
   task automatic run_txn(input logic [N-1:0] mask, input int req_dly, input int resp_dly,
                          input int dlv_dly, output int w_obs);
      int          w_exp;
      logic [N-1:0] oh, rdy;
      logic [AW-1:0] ea;
      logic [1:0]  eo, er;
      logic [31:0] ed, erd;
      logic        timed_out;
      new_payload();
      in_req_valid   = mask;
      dmi_req_ready  = 1'b0;
      dmi_resp_valid = 1'b0;
      in_resp_ready  = '0;
      w_exp = exp_winner(mask);
      oh    = N'(1) << w_exp;
      #1;
      chk("grant_ready", in_req_ready, oh);
      chk("idle_not_busy", busy, 0);
      w_obs = (in_req_ready == 2'b10) ? 1 : 0;
      ea = m_addr[w_exp];
      eo = m_op[w_exp];
      ed = m_data[w_exp];
      tick();
      lg_m = w_exp;
      in_req_valid = '1;
      new_payload();
      for (int d = 0; d <= req_dly; d++) begin
         dmi_req_ready = (d == req_dly);
         #1;
         chk("req_valid", dmi_req_valid, 1);
         chk("req_addr", dmi_req_addr, ea);
         chk("req_op", dmi_req_op, eo);
         chk("req_data", dmi_req_data, ed);
         chk("req_resp_ready", dmi_resp_ready, 0);
         chk("req_no_grant", in_req_ready, 0);
         chk("req_owner", owner, w_exp);
         tick();
      end
      dmi_req_ready = 1'b0;
      timed_out = 1'b0;
      er  = 2'($urandom);
      erd = $urandom;
      for (int c = 0; c < TO; c++) begin
         dmi_resp_valid = (c == resp_dly);
         dmi_resp_resp  = er;
         dmi_resp_data  = erd;
         #1;
         chk("resp_ready", dmi_resp_ready, 1);
         chk("resp_req_idle", dmi_req_valid, 0);
         chk("resp_no_grant", in_req_ready, 0);
         chk("resp_no_up", in_resp_valid, 0);
         tick();
         if (c == resp_dly) break;
         if (c == TO - 1) timed_out = 1'b1;
      end
      dmi_resp_valid = 1'b0;
      if (timed_out) begin
         er  = 2'd2;
         erd = 32'd0;
         if (tcnt_m < 255) tcnt_m++;
      end
      for (int d = 0; d <= dlv_dly; d++) begin
         rdy = N'($urandom);
         rdy[w_exp] = (d == dlv_dly);
         in_resp_ready = rdy;
         #1;
         chk("dlv_valid", in_resp_valid, oh);
         chk("dlv_resp", in_resp_resp, er);
         chk("dlv_data", in_resp_data, erd);
         chk("dlv_no_grant", in_req_ready, 0);
         chk("dlv_busy", busy, 1);
         tick();
      end
      in_resp_ready = '0;
      in_req_valid  = '0;
      chk("post_idle", busy, 0);
      chk("timeout_cnt", timeout_cnt, tcnt_m);
      chk("stray", stray_resp, stray_m);
   endtask

   initial begin
      int w;
      int exp_w;
      reset = 1'b1;
      in_req_valid = '0; in_req_addr = '0; in_req_op = '0; in_req_data = '0;
      in_resp_ready = '0; dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0;
      dmi_resp_resp = '0; dmi_resp_data = '0;
      lg_m = N - 1; tcnt_m = 0; stray_m = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, N - 1);
      chk("rst_stray", stray_resp, 0);
      chk("rst_tcnt", timeout_cnt, 0);
      chk("rst_resp_ready", dmi_resp_ready, 1);
      chk("rst_req_valid", dmi_req_valid, 0);
      chk("rst_up_valid", in_resp_valid, 0);
      chk("rst_up_ready", in_req_ready, 0);
      tick();

      // single requester, minimum latency
      m_addr[0] = 7'h10; m_op[0] = 2'd2; m_data[0] = 32'hDEADBEEF;
      m_addr[1] = 7'h00; m_op[1] = 2'd0; m_data[1] = 32'h0;
      drive_payload();
      in_req_valid = 2'b01;
      dmi_req_ready = 1'b1;
      #1;
      chk("t1_ready", in_req_ready, 2'b01);
      tick();
      in_req_valid = 2'b00;
      chk("t1_req_valid", dmi_req_valid, 1);
      chk("t1_req_addr", dmi_req_addr, 7'h10);
      chk("t1_req_op", dmi_req_op, 2);
      chk("t1_req_data", dmi_req_data, 32'hDEADBEEF);
      chk("t1_owner", owner, 0);
      tick();
      dmi_req_ready = 1'b0;
      dmi_resp_valid = 1'b1; dmi_resp_resp = 2'd0; dmi_resp_data = 32'h12345678;
      tick();
      dmi_resp_valid = 1'b0;
      chk("t1_up_valid", in_resp_valid, 2'b01);
      chk("t1_up_resp", in_resp_resp, 0);
      chk("t1_up_data", in_resp_data, 32'h12345678);
      in_resp_ready = 2'b01;
      tick();
      in_resp_ready = 2'b00;
      chk("t1_done", busy, 0);
      chk("t1_up_clear", in_resp_valid, 0);
      lg_m = 0;

      // response in the same cycle as the timeout terminal count
      run_txn(2'b01, 0, TO - 1, 0, w);
      chk("t5_tcnt_zero", timeout_cnt, 0);

      // backpressure on both sides
      run_txn(2'b01, 5, 0, 3, w);

      // timeout, then a late response is dropped as stray
      run_txn(2'b01, 0, 100, 0, w);
      chk("t4_tcnt_one", timeout_cnt, 1);
      dmi_resp_valid = 1'b1;
      #1;
      chk("t4_no_up", in_resp_valid, 0);
      tick();
      dmi_resp_valid = 1'b0;
      stray_m = 1'b1;
      chk("t4_stray", stray_resp, 1);
      chk("t4_idle", busy, 0);

      // reset while waiting in RESP
      new_payload();
      in_req_valid = 2'b10;
      exp_w = exp_winner(2'b10);
      #1;
      chk("t6_ready", in_req_ready, N'(1) << exp_w);
      tick();
      in_req_valid = '0;
      dmi_req_ready = 1'b1;
      tick();
      dmi_req_ready = 1'b0;
      tick();
      chk("t6_in_resp", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      lg_m = N - 1; tcnt_m = 0; stray_m = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_req_valid", dmi_req_valid, 0);
      chk("t6_up_valid", in_resp_valid, 0);
      chk("t6_owner", owner, N - 1);
      chk("t6_tcnt", timeout_cnt, 0);
      chk("t6_stray", stray_resp, 0);

      // round robin with both requesters always valid: 0,1,0,1
      for (int k = 0; k < 4; k++) begin
         run_txn(2'b11, k % 2, k, k % 3, w);
         chk("rr_order", w, k % 2);
      end

      // randomized traffic, including occasional timeouts and idle gaps
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_req_valid = '0;
            #1;
            chk("gap_no_grant", in_req_ready, 0);
            chk("gap_idle", busy, 0);
            tick();
         end
         run_txn(N'($urandom_range(1, 3)), $urandom_range(0, 4), $urandom_range(0, 20),
                 $urandom_range(0, 3), w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
